// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load arbiter.
// The block and its memory both take their depth from here.
package imem_pkg;

  typedef enum logic [2:0] {
    RUN,
    HDR0,
    HDR1,
    DATA,
    WRITE,
    DONE
  } state_t;

  localparam int          IMEM_DEPTH_DEF = 128;
  localparam logic [31:0] HALT_INSTR_DEF = 32'h0000_0063;  // beq x0,x0,0

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word packer: four shifts fill one 32-bit word.
// word_valid flags the shift that completes the word.
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0] byte_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (shift) begin
      word[8*byte_cnt +: 8] <= byte_in;
      byte_cnt              <= byte_cnt + 2'd1;
    end
  end

  assign word_valid = shift && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_load_arbiter.sv
// Shares the instruction-memory port between CPU fetch and a byte-serial
// loader; the CPU is stalled on HALT_INSTR while a load is in progress.
module imem_load_arbiter
  import imem_pkg::*;
#(
  parameter int          IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int          IDX_W      = 10,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      fetch_addr,
  output logic [31:0]      fetch_instr,
  output logic             fetch_stall,
  input  logic             ld_start,
  input  logic             ld_valid,
  input  logic [7:0]       ld_byte,
  output logic             ld_ready,
  output logic             ld_done,
  output logic             ld_err,
  output logic [15:0]      loaded_words,
  output logic [IDX_W-1:0] mem_idx,
  input  logic [31:0]      mem_rdata,
  output logic             mem_we,
  output logic [31:0]      mem_wdata
);

  localparam logic [16:0] DEPTH = 17'(IMEM_DEPTH);

  state_t      state, state_nxt;
  logic [15:0] count, wr_ptr, words_seen;
  logic [IDX_W-1:0] fetch_idx;
  logic        xfer, wr_in_range, last_word, word_valid;
  logic [31:0] word;
  logic        unused_addr_bits;

  assign fetch_idx        = fetch_addr[IDX_W+1:2];
  assign unused_addr_bits = ^{fetch_addr[31:IDX_W+2], fetch_addr[1:0]};

  // ld_ready decodes state only, so the handshake never loops through the FSM logic.
  assign ld_ready    = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign xfer        = ld_valid && ld_ready;
  assign wr_in_range = {1'b0, wr_ptr} < DEPTH;
  assign last_word   = ({1'b0, words_seen} + 17'd1) == {1'b0, count};
  assign mem_wdata   = word;

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      ((state == RUN) && ld_start),
    .shift      (xfer && (state == DATA)),
    .byte_in    (ld_byte),
    .word       (word),
    .word_valid (word_valid)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    fetch_stall = 1'b1;
    fetch_instr = HALT_INSTR;
    mem_idx     = fetch_idx;
    mem_we      = 1'b0;
    ld_done     = 1'b0;
    case (state)
      RUN: begin
        fetch_stall = 1'b0;
        if (17'(fetch_idx) < DEPTH) fetch_instr = mem_rdata;
        if (ld_start) state_nxt = HDR0;
      end
      HDR0: if (xfer) state_nxt = HDR1;
      HDR1: if (xfer) state_nxt = ({ld_byte, count[7:0]} == 16'd0) ? DONE : DATA;
      DATA: if (word_valid) state_nxt = WRITE;
      WRITE: begin
        mem_idx   = wr_ptr[IDX_W-1:0];
        mem_we    = wr_in_range;
        state_nxt = last_word ? DONE : DATA;
      end
      DONE: begin
        ld_done   = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      count        <= '0;
      wr_ptr       <= '0;
      words_seen   <= '0;
      loaded_words <= '0;
      ld_err       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        RUN: if (ld_start) begin
          ld_err       <= 1'b0;
          loaded_words <= '0;
          wr_ptr       <= '0;
          words_seen   <= '0;
        end
        HDR0: if (xfer) count[7:0]  <= ld_byte;
        HDR1: if (xfer) count[15:8] <= ld_byte;
        WRITE: begin
          // Words past the end of memory are consumed but dropped.
          if (wr_in_range) loaded_words <= loaded_words + 16'd1;
          else             ld_err       <= 1'b1;
          wr_ptr     <= wr_ptr + 16'd1;
          words_seen <= words_seen + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Owns the single port of a writable instruction memory and shares it between the CPU fetch path and a byte-serial program loader.
- In RUN state, fetch passes through combinationally: word index is fetch_addr[11:2]; an out-of-range index returns HALT_INSTR.
- On ld_start the block stalls the CPU, accepts a length-prefixed byte stream, packs the bytes into little-endian words and writes them from index 0 upward, then releases the CPU.

Parameters:
- IMEM_DEPTH, 128: number of valid instruction words.
- IDX_W, 10: word-index width; the index is taken from addr[IDX_W+1:2].
- HALT_INSTR, 32'h00000063: word returned for out-of-range or stalled fetch (beq x0,x0,0 self-loop).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_addr  in  32  CPU PC.
- fetch_instr  out  32  instruction to CPU.
- fetch_stall  out  1  CPU must hold PC while high.
- ld_start  in  1  one-cycle pulse; begins a load.
- ld_valid  in  1  ld_byte is valid.
- ld_byte  in  8  stream byte.
- ld_ready  out  1  block accepts ld_byte this cycle.
- ld_done  out  1  one-cycle pulse when the load finishes.
- ld_err  out  1  sticky; words were dropped because the load exceeded IMEM_DEPTH.
- loaded_words  out  16  words actually written by the last load.
- mem_idx  out  IDX_W  word index to the memory.
- mem_rdata  in  32  combinational read data.
- mem_we  out  1  write enable.
- mem_wdata  out  32  write data.

Behaviour:
- Reset values: state=RUN, fetch_stall=0, ld_ready=0, ld_done=0, ld_err=0, loaded_words=0, mem_we=0, internal pointers=0. Memory contents are not touched by reset.
- A byte transfers on ld_valid && ld_ready.
- RUN:
  - mem_idx=fetch_addr[11:2]; fetch_instr = (idx < IMEM_DEPTH) ? mem_rdata : HALT_INSTR. Zero latency.
  - fetch_addr[1:0] is ignored.
  - ld_ready=0.
  - ld_start -> HDR0; clear ld_err, loaded_words, wr_ptr and byte_cnt.
- Every state other than RUN: fetch_stall=1 and fetch_instr=HALT_INSTR.
- HDR0: ld_ready=1; on transfer, count[7:0]=byte, go to HDR1.
- HDR1: ld_ready=1; on transfer, count[15:8]=byte. If the full 16-bit count is 0, go to DONE; otherwise go to DATA.
- DATA:
  - ld_ready=1; each transfer shifts the byte into word[8*byte_cnt +: 8] (little-endian).
  - byte_cnt wraps 0..3; the transfer with byte_cnt=3 goes to WRITE.
- WRITE (exactly 1 cycle):
  - ld_ready=0, mem_idx=wr_ptr, mem_wdata=assembled word.
  - If wr_ptr < IMEM_DEPTH: mem_we=1 and loaded_words+=1. Otherwise mem_we=0 and ld_err<=1 (byte is consumed, word is dropped).
  - wr_ptr+=1 and words_seen+=1. If words_seen+1 == count, go to DONE; else go to DATA.
- DONE (1 cycle): ld_done=1, fetch_stall=1, then RUN. The CPU sees real instructions from the next cycle.
- ld_start in any state other than RUN is ignored; no restart mid-load.
- ld_valid while ld_ready=0 is held by the source and not lost.
- mem_we is asserted only in WRITE. mem_idx in WRITE is wr_ptr truncated to IDX_W; no write occurs when wr_ptr >= IMEM_DEPTH.
- rst mid-load: synchronous return to RUN. Words already written stay; the partial word is discarded; ld_done is not pulsed.
- A count of 65535 is legal; words beyond IMEM_DEPTH set ld_err.

Decomposition:
- Shared package imem_pkg holds:
  - state enum RUN/HDR0/HDR1/DATA/WRITE/DONE;
  - HALT_INSTR;
  - IMEM_DEPTH default, so that the block and its memory agree.
- One natural sub-module, imem_byte_packer: byte_cnt plus 32-bit shift-in, with outputs word and word_valid.
- The FSM, counters and fetch mux stay in the top module.

Test Plan:
- Reset then RUN: preload mem[5]=0x00500093; fetch_addr=0x14 -> fetch_instr=0x00500093 and fetch_stall=0 in the same cycle; fetch_addr=0x200 (idx 128) -> 0x00000063.
- Load 2 words: ld_start, then bytes 02 00 13 05 A0 00 93 05 B0 00 with ld_valid held -> mem[0]=0x00A00513 and mem[1]=0x00B00593 each written in one WRITE cycle; ld_ready low on those cycles; ld_done pulses once; loaded_words=2; fetch_stall high from the cycle after ld_start through DONE.
- Zero-length: bytes 00 00 -> DONE directly, no mem_we, loaded_words=0, ld_err=0.
- Overflow: count=130 with IMEM_DEPTH=128 -> 128 mem_we pulses (idx 0..127), 130 WRITE cycles, ld_err=1, loaded_words=128; ld_err clears on the next ld_start.
- Gapped stream: ld_valid toggles every other cycle -> same memory image as the back-to-back case; no duplicate or lost bytes.
- Reset mid-load: rst asserted after 6 data bytes -> next cycle state=RUN, fetch_stall=0, mem[0] written, mem[1] unchanged, no ld_done; ld_start during DATA is ignored.
